// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and state encoding for the MIPS fetch stage
package mips_pkg;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_RUN  = 2'd1,
    IF_HALT = 2'd2
  } ifState_t;

endpackage

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - word-wide instruction store, sync write, async read
module instruction_memory #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          writeEn,
  input  logic [AW-1:0] writeAddr,
  input  logic [31:0]   writeData,
  input  logic [AW-1:0] readAddr,
  output logic [31:0]   readData
);

  logic [31:0] mem [DEPTH];

  // Debug-unit loads; contents survive reset, and a same-cycle read sees the old word
  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem[writeAddr] <= writeData;
    end
  end

  assign readData = mem[readAddr];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: PC, instruction memory and IF/ID register
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter int          IMEM_AW    = 8,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               PC_write,
  input  logic               IF_ID_write,
  input  logic               jump_take,
  input  logic [31:0]        jump_addr,
  input  logic               branch_take,
  input  logic [31:0]        branch_addr,
  input  logic               IF_flush,
  input  logic               stop_debug,
  input  logic               step_debug,
  input  logic               load_en,
  input  logic [IMEM_AW-1:0] load_addr,
  input  logic [31:0]        load_data,
  output logic [31:0]        out_instruction,
  output logic [31:0]        out_instruction_address,
  output logic               out_valid,
  output logic [31:0]        out_pc,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  ifState_t    state;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] fetchWord;
  logic        active;

  logic [31:0] pcNext;
  logic        ifIdLoad;
  logic [31:0] instrNext;
  logic [31:0] addrNext;
  logic        validNext;
  logic        countInc;
  logic        goHalt;

  instruction_memory #(
    .DEPTH(IMEM_DEPTH),
    .AW   (IMEM_AW)
  ) imem (
    .clk      (clk),
    .writeEn  (load_en),
    .writeAddr(load_addr),
    .writeData(load_data),
    .readAddr (pc[IMEM_AW+1:2]),
    .readData (fetchWord)
  );

  assign pcPlus4 = pc + PC_STEP;
  assign active  = (state == IF_RUN) && (!stop_debug || step_debug);

  // Redirect/stall priority for an active RUN cycle; IF/ID updates gated by IF_ID_write below the stall
  always_comb begin
    pcNext    = pc;
    ifIdLoad  = 1'b0;
    instrNext = NOP_WORD;
    addrNext  = 32'h0;
    validNext = 1'b0;
    countInc  = 1'b0;
    goHalt    = 1'b0;
    if (branch_take) begin
      pcNext   = branch_addr;
      ifIdLoad = 1'b1;
    end else if (!PC_write) begin
      ifIdLoad = IF_ID_write;
    end else if (jump_take) begin
      pcNext   = jump_addr;
      ifIdLoad = IF_ID_write;
    end else if (IF_flush) begin
      pcNext   = pcPlus4;
      ifIdLoad = IF_ID_write;
    end else if (fetchWord == HALT_WORD) begin
      instrNext = HALT_WORD;
      addrNext  = pcPlus4;
      validNext = 1'b1;
      ifIdLoad  = IF_ID_write;
      countInc  = 1'b1;
      goHalt    = 1'b1;
    end else begin
      pcNext    = pcPlus4;
      instrNext = fetchWord;
      addrNext  = pcPlus4;
      validNext = 1'b1;
      ifIdLoad  = IF_ID_write;
      countInc  = 1'b1;
    end
  end

  // Stage state machine: IDLE/HALT inject bubbles, RUN applies the selection when active
  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= IF_IDLE;
      pc                      <= 32'h0;
      out_instruction         <= NOP_WORD;
      out_instruction_address <= 32'h0;
      out_valid               <= 1'b0;
      fetch_count             <= 32'h0;
    end else begin
      case (state)
        IF_IDLE: begin
          pc                      <= 32'h0;
          out_instruction         <= NOP_WORD;
          out_instruction_address <= 32'h0;
          out_valid               <= 1'b0;
          if (start) state <= IF_RUN;
        end
        IF_RUN: begin
          if (active) begin
            pc <= pcNext;
            if (ifIdLoad) begin
              out_instruction         <= instrNext;
              out_instruction_address <= addrNext;
              out_valid               <= validNext;
            end
            if (countInc) fetch_count <= fetch_count + 32'd1;
            if (goHalt) state <= IF_HALT;
          end
        end
        IF_HALT: begin
          out_instruction         <= NOP_WORD;
          out_instruction_address <= 32'h0;
          out_valid               <= 1'b0;
        end
        default: state <= IF_IDLE;
      endcase
    end
  end

  assign out_pc = pc;
  assign halted = (state == IF_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed vector bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        PC_write;
  logic        IF_ID_write;
  logic        jump_take;
  logic [31:0] jump_addr;
  logic        branch_take;
  logic [31:0] branch_addr;
  logic        IF_flush;
  logic        stop_debug;
  logic        step_debug;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] out_instruction;
  logic [31:0] out_instruction_address;
  logic        out_valid;
  logic [31:0] out_pc;
  logic        halted;
  logic [31:0] fetch_count;

  int vectors = 0;
  int miscompares = 0;

  instruction_fetch dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .PC_write               (PC_write),
    .IF_ID_write            (IF_ID_write),
    .jump_take              (jump_take),
    .jump_addr              (jump_addr),
    .branch_take            (branch_take),
    .branch_addr            (branch_addr),
    .IF_flush               (IF_flush),
    .stop_debug             (stop_debug),
    .step_debug             (step_debug),
    .load_en                (load_en),
    .load_addr              (load_addr),
    .load_data              (load_data),
    .out_instruction        (out_instruction),
    .out_instruction_address(out_instruction_address),
    .out_valid              (out_valid),
    .out_pc                 (out_pc),
    .halted                 (halted),
    .fetch_count            (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pcw, ifidw, jt;
    logic [31:0] ja;
    logic        bt;
    logic [31:0] ba;
    logic        fl, sd, st, le;
    logic [7:0]  la;
    logic [31:0] ld;
    logic [31:0] ePc, eInstr, eAddr;
    logic        eValid;
    logic [31:0] eCount;
    logic        eHalt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic pcw, ifidw, jt, input logic [31:0] ja,
    input logic bt, input logic [31:0] ba,
    input logic fl, sd, st, le, input logic [7:0] la, input logic [31:0] ld,
    input logic [31:0] ePc, eInstr, eAddr, input logic eValid,
    input logic [31:0] eCount, input logic eHalt);
    vec_t v;
    v.pcw = pcw; v.ifidw = ifidw; v.jt = jt; v.ja = ja; v.bt = bt; v.ba = ba;
    v.fl = fl; v.sd = sd; v.st = st; v.le = le; v.la = la; v.ld = ld;
    v.ePc = ePc; v.eInstr = eInstr; v.eAddr = eAddr; v.eValid = eValid;
    v.eCount = eCount; v.eHalt = eHalt;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] ePc, eInstr, eAddr,
                          input logic eValid, input logic [31:0] eCount, input logic eHalt);
    check({tag, " pc"}, out_pc, ePc);
    check({tag, " instr"}, out_instruction, eInstr);
    check({tag, " addr"}, out_instruction_address, eAddr);
    check({tag, " valid"}, {31'h0, out_valid}, {31'h0, eValid});
    check({tag, " count"}, fetch_count, eCount);
    check({tag, " halted"}, {31'h0, halted}, {31'h0, eHalt});
  endtask

  task automatic idleInputs();
    start = 0; PC_write = 1; IF_ID_write = 1; jump_take = 0; jump_addr = 0;
    branch_take = 0; branch_addr = 0; IF_flush = 0; stop_debug = 0; step_debug = 0;
    load_en = 0; load_addr = 0; load_data = 0;
  endtask

  task automatic loadWord(input logic [7:0] a, input logic [31:0] d);
    load_en = 1; load_addr = a; load_data = d;
    step();
    load_en = 0;
  endtask

  // Program of three words ending in the halt encoding, started from reset
  task automatic runScenario1(input string tag);
    start = 1;
    step();
    start = 0;
    checkAll({tag, " started"}, 32'h0, 32'h0, 32'h0, 0, 32'd0, 0);
    step();
    checkAll({tag, " f0"}, 32'h4, 32'h2001_0005, 32'h4, 1, 32'd1, 0);
    step();
    checkAll({tag, " f1"}, 32'h8, 32'h2002_0007, 32'h8, 1, 32'd2, 0);
    step();
    checkAll({tag, " f2"}, 32'h8, 32'hFFFF_FFFF, 32'hC, 1, 32'd3, 1);
    step();
    checkAll({tag, " halt"}, 32'h8, 32'h0, 32'h0, 0, 32'd3, 1);
  endtask

  initial begin
    idleInputs();
    rst = 1;
    loadWord(8'd0, 32'h2001_0005);
    loadWord(8'd1, 32'h2002_0007);
    loadWord(8'd2, 32'hFFFF_FFFF);
    step();
    rst = 0;
    checkAll("reset", 32'h0, 32'h0, 32'h0, 0, 32'd0, 0);
    step();
    checkAll("idle hold", 32'h0, 32'h0, 32'h0, 0, 32'd0, 0);

    runScenario1("s1");

    rst = 1;
    step();
    rst = 0;
    checkAll("rst in halt", 32'h0, 32'h0, 32'h0, 0, 32'd0, 0);
    runScenario1("s1 again");

    rst = 1;
    for (int i = 0; i < 32; i++) loadWord(i[7:0], 32'hA000_0000 | i);
    loadWord(8'hFF, 32'hA000_00FF);
    rst = 0;
    start = 1;
    step();
    start = 0;

    //           pcw ifw jt ja          bt ba            fl sd st le la    ld              pc            instr          addr          v  cnt    h
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'h4,        32'hA000_0000, 32'h4,        1, 32'd1,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'h8,        32'hA000_0001, 32'h8,        1, 32'd2,  0));
    vecs.push_back(mk(1, 1, 1, 32'h40, 0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'h40,       32'h0,         32'h0,        0, 32'd2,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'h44,       32'hA000_0010, 32'h44,       1, 32'd3,  0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'h44,       32'hA000_0010, 32'h44,       1, 32'd3,  0));
    vecs.push_back(mk(0, 0, 1, 32'h80, 0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'h44,       32'hA000_0010, 32'h44,       1, 32'd3,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'h48,       32'hA000_0011, 32'h48,       1, 32'd4,  0));
    vecs.push_back(mk(0, 0, 1, 32'h80, 1, 32'h20,        0, 0, 0, 0, 8'd0, 32'h0,          32'h20,       32'h0,         32'h0,        0, 32'd4,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'h24,       32'hA000_0008, 32'h24,       1, 32'd5,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         1, 0, 0, 0, 8'd0, 32'h0,          32'h28,       32'h0,         32'h0,        0, 32'd5,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 1, 0, 0, 8'd0, 32'h0,          32'h28,       32'h0,         32'h0,        0, 32'd5,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 1, 1, 0, 8'd0, 32'h0,          32'h2C,       32'hA000_000A, 32'h2C,       1, 32'd6,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 1, 0, 0, 8'd0, 32'h0,          32'h2C,       32'hA000_000A, 32'h2C,       1, 32'd6,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 1, 0, 0, 8'd0, 32'h0,          32'h2C,       32'hA000_000A, 32'h2C,       1, 32'd6,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 1, 0, 0, 8'd0, 32'h0,          32'h2C,       32'hA000_000A, 32'h2C,       1, 32'd6,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'h30,       32'hA000_000B, 32'h30,       1, 32'd7,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 32'h10,        0, 0, 0, 0, 8'd0, 32'h0,          32'h10,       32'h0,         32'h0,        0, 32'd7,  0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'h10,       32'h0,         32'h0,        0, 32'd7,  0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'h10,       32'h0,         32'h0,        0, 32'd7,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'h14,       32'hA000_0004, 32'h14,       1, 32'd8,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 32'hFFFF_FFFC, 0, 0, 0, 0, 8'd0, 32'h0,          32'hFFFF_FFFC,32'h0,         32'h0,        0, 32'd8,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'h0,        32'hA000_00FF, 32'h0,        1, 32'd9,  0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'h4,        32'hA000_0000, 32'h4,        1, 32'd10, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 0, 0, 1, 8'd1, 32'h1234_5678,  32'h8,        32'hA000_0001, 32'h8,        1, 32'd11, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 32'h4,         0, 0, 0, 0, 8'd0, 32'h0,          32'h4,        32'h0,         32'h0,        0, 32'd11, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'h8,        32'h1234_5678, 32'h8,        1, 32'd12, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 0, 0, 1, 8'd3, 32'hFFFF_FFFF,  32'hC,        32'hA000_0002, 32'hC,        1, 32'd13, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'hC,        32'hFFFF_FFFF, 32'h10,       1, 32'd14, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,         0, 0, 0, 0, 8'd0, 32'h0,          32'hC,        32'h0,         32'h0,        0, 32'd14, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0,  1, 32'h40,        0, 0, 0, 0, 8'd0, 32'h0,          32'hC,        32'h0,         32'h0,        0, 32'd14, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      PC_write = vecs[i].pcw; IF_ID_write = vecs[i].ifidw;
      jump_take = vecs[i].jt; jump_addr = vecs[i].ja;
      branch_take = vecs[i].bt; branch_addr = vecs[i].ba;
      IF_flush = vecs[i].fl; stop_debug = vecs[i].sd; step_debug = vecs[i].st;
      load_en = vecs[i].le; load_addr = vecs[i].la; load_data = vecs[i].ld;
      step();
      checkAll($sformatf("row%0d", i), vecs[i].ePc, vecs[i].eInstr, vecs[i].eAddr,
               vecs[i].eValid, vecs[i].eCount, vecs[i].eHalt);
    end
    idleInputs();

    rst = 1;
    step();
    rst = 0;
    start = 1;
    step();
    start = 0;
    step();
    checkAll("pre-stall", 32'h4, 32'hA000_0000, 32'h4, 1, 32'd1, 0);
    PC_write = 0; IF_ID_write = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    checkAll("rst in stall", 32'h0, 32'h0, 32'h0, 0, 32'd0, 0);
    PC_write = 1; IF_ID_write = 1;
    step();
    checkAll("idle after rst", 32'h0, 32'h0, 32'h0, 0, 32'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the 5-stage MIPS pipeline: owns the PC, the instruction memory (loaded by the debug unit), and the IF/ID pipeline register that feeds instruction decode.
- Applies hazard-unit stalls, jump redirects from ID, branch redirects/flushes from later stages, debug stop/single-step, and halt detection.
- Updates on posedge clk, so decode can sample the IF/ID register on the following negedge.

Parameters:
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words (power of 2).
- IMEM_AW, 8, word-address width, equal to log2(IMEM_DEPTH).
- HALT_WORD, 32'hFFFF_FFFF, encoding that halts fetch.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; leaves IDLE and begins fetching at PC 0.
- PC_write  in  1  from hazard unit; 0 holds PC.
- IF_ID_write  in  1  from hazard unit; 0 holds the IF/ID register.
- jump_take  in  1  jump decoded in ID.
- jump_addr  in  32  jump target.
- branch_take  in  1  branch resolved taken downstream.
- branch_addr  in  32  branch target.
- IF_flush  in  1  squash the instruction being fetched this cycle.
- stop_debug  in  1  freeze the stage.
- step_debug  in  1  while stop_debug=1, perform exactly one RUN cycle.
- load_en  in  1  instruction memory write enable.
- load_addr  in  IMEM_AW  word address for the write.
- load_data  in  32  word to write.
- out_instruction  out  32  IF/ID instruction.
- out_instruction_address  out  32  IF/ID PC+4 of that instruction.
- out_valid  out  1  IF/ID holds a real (non-bubble) instruction.
- out_pc  out  32  current PC.
- halted  out  1  stage is in HALT.
- fetch_count  out  32  number of accepted fetches.

Behaviour:
- Reset: PC=0, out_instruction=0 (NOP), out_instruction_address=0, out_valid=0, halted=0, fetch_count=0, state=IDLE. Memory contents are not reset.
- Memory: combinational read at word index PC[IMEM_AW+1:2]; PC upper bits are ignored, so addresses wrap. Write is synchronous on load_en and is accepted in any state. A write and a fetch to the same word in the same cycle: the fetch gets the old data.
- States: IDLE, RUN, HALT.
- IDLE: PC holds at 0, IF/ID loads NOP with valid=0. start moves to RUN next cycle.
- HALT: halted=1, PC frozen, IF/ID loads NOP with valid=0. Exit only via rst.
- Active cycle definition: state is RUN and (stop_debug=0 or step_debug=1). When not active in RUN, all registers hold, including fetch_count.
- In an active cycle, evaluated in priority order:
  1. branch_take: PC<=branch_addr; IF/ID<=NOP, valid=0. Overrides PC_write and IF_ID_write.
  2. PC_write=0: PC holds. If IF_ID_write=0, IF/ID also holds. jump_take and IF_flush are ignored this cycle; ID re-asserts them after the stall.
  3. jump_take: PC<=jump_addr; IF/ID<=NOP, valid=0.
  4. IF_flush: PC<=PC+4; IF/ID<=NOP, valid=0.
  5. Fetched word == HALT_WORD: IF/ID<=HALT_WORD, address PC+4, valid=1; PC holds; state<=HALT next cycle.
  6. Otherwise: IF/ID<=imem[PC], out_instruction_address<=PC+4, valid=1; PC<=PC+4; fetch_count increments.
- PC_write=1 with IF_ID_write=0 is not produced by the hazard unit. If it occurs, PC advances and IF/ID holds.
- fetch_count increments only in cases 5 and 6. It wraps modulo 2^32.
- PC+4 wraps modulo 2^32.
- Latency: memory word to out_instruction is one clock.
- rst asserted in any state or mid-stall: reset values on the next edge.

Decomposition:
- Package mips_pkg: NOP_WORD (32'h0), HALT_WORD, IF state enum (IDLE/RUN/HALT), PC_STEP (4).
- One sub-module: instruction_memory (sync write, async read, parameterised by IMEM_DEPTH).
- Next-PC and IF/ID selection stay in instruction_fetch.

Test Plan:
- Load words 0x20010005, 0x20020007, 0xFFFFFFFF at words 0..2, then rst, then start -> out_instruction 0x20010005 (addr 4), then 0x20020007 (addr 8), then 0xFFFFFFFF (addr 12); halted=1 on the following cycle; PC frozen at 8; fetch_count=3.
- RUN at PC=0x10 with PC_write=0, IF_ID_write=0 for 2 cycles -> PC stays 0x10 and IF/ID unchanged; on release, fetches imem[4].
- jump_take=1, jump_addr=0x40 at PC=0x08 -> next cycle PC=0x40 and valid=0; the cycle after, fetches imem[16].
- branch_take=1, branch_addr=0x20 together with PC_write=0 and jump_take=1 -> PC=0x20, IF/ID NOP (branch wins).
- stop_debug=1 for 5 cycles with one step_debug pulse -> PC advances by exactly 4 and fetch_count by exactly 1.
- Assert rst during HALT or during a stall -> all outputs return to reset values and state is IDLE; memory retains its contents (restart reproduces the first scenario).
